// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Optional watchdog feature in wrr_arbiter is enabled by defining WRR_TIMEOUT_EN.
package wrr_arbiter_pkg;

    localparam int MAX_REQ      = 32;
    localparam int MAX_WEIGHT_W = 16;

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // A zero weight would starve the owner of its own grant, so it counts as one.
    function automatic logic [MAX_WEIGHT_W-1:0] eff_weight(input logic [MAX_WEIGHT_W-1:0] w);
        return (w == '0) ? MAX_WEIGHT_W'(1) : w;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int k;
        k       = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[IW'(k)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with transaction locking for one shared resource.
// Define WRR_TIMEOUT_EN to add a watchdog that revokes a grant held TIMEOUT_CYC cycles without done_i.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WEIGHT_W    = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
    input  logic                         done_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id_o,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1 || WEIGHT_W > MAX_WEIGHT_W) begin : g_cfg_check
        $error("wrr_arbiter: unsupported parameter combination");
    end

    state_e               state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDW-1:0]       id_q;
    logic [IDW-1:0]       ptr_q;
    logic [WEIGHT_W-1:0]  credit_q;

    logic [IDW-1:0]       next_ptr;
    logic [IDW-1:0]       pick_ptr;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_valid;
    logic [WEIGHT_W-1:0]  w_sel;
    logic [WEIGHT_W-1:0]  credit_load;
    logic                 owner_req;
    logic                 expire;

    // While owning, the picker already looks from owner+1 so a release can hand over with no bubble.
    always_comb begin
        next_ptr  = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
        pick_ptr  = (state_q == OWN) ? next_ptr : ptr_q;
        owner_req = req_i[id_q];
        w_sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDW'(k)) begin
                w_sel = weight_i[k*WEIGHT_W +: WEIGHT_W];
            end
        end
        credit_load = WEIGHT_W'(eff_weight(MAX_WEIGHT_W'(w_sel)) - MAX_WEIGHT_W'(1));
    end

    rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .req_i   (req_i),
        .ptr_i   (pick_ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef WRR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q;
    logic          timeout_q;
    assign expire    = (timer_q == TW'(TIMEOUT_CYC - 1));
    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
`ifdef WRR_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef WRR_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q  <= OWN;
                        gnt_q    <= NUM_REQ'(onehot(int'(pick_idx)));
                        id_q     <= pick_idx;
                        credit_q <= credit_load;
`ifdef WRR_TIMEOUT_EN
                        timer_q  <= '0;
`endif
                    end
                end
                OWN: begin
                    if (done_i && credit_q != '0 && owner_req) begin
                        credit_q <= credit_q - 1'b1;
`ifdef WRR_TIMEOUT_EN
                        timer_q  <= '0;
`endif
                    end else if (done_i || expire) begin
                        // A watchdog revoke behaves exactly like a credit-exhausted done.
                        ptr_q <= next_ptr;
`ifdef WRR_TIMEOUT_EN
                        timeout_q <= !done_i;
                        timer_q   <= '0;
`endif
                        if (pick_valid) begin
                            gnt_q    <= NUM_REQ'(onehot(int'(pick_idx)));
                            id_q     <= pick_idx;
                            credit_q <= credit_load;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else begin
`ifdef WRR_TIMEOUT_EN
                        timer_q <= timer_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = id_q;
    assign busy_o   = |gnt_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (NUM_REQ=4, WEIGHT_W=4, TIMEOUT_CYC=8).
module tb_wrr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] weight;
    logic        done;
    logic [3:0]  gnt;
    logic [1:0]  gntId;
    logic        busy;
    logic        timeout;

    int checkCount;
    int errorCount;

    wrr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4), .TIMEOUT_CYC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .weight_i  (weight),
        .done_i    (done),
        .gnt_o     (gnt),
        .gnt_id_o  (gntId),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic d);
        reset = rst;
        req   = r;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [1:0] expId,
                               input logic expBusy, input logic expTimeout);
        checkCount++;
        assert ({gnt, gntId, busy, timeout} === {expGnt, expId, expBusy, expTimeout}) else begin
            errorCount++;
            $display("[TB] FAIL %s got gnt=%b id=%0d busy=%b to=%b exp gnt=%b id=%0d busy=%b to=%b",
                     tag, gnt, gntId, busy, timeout, expGnt, expId, expBusy, expTimeout);
            $error("[TB] check %s", tag);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        weight     = 16'h1111;

        // Reset dominates pending requests
        applyStimulus(1'b1, 4'hF, 1'b0);
        checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'hF, 1'b0);
        checkOutput("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Equal weights, done every cycle: strict rotation, no idle cycles
        applyStimulus(1'b0, 4'hF, 1'b1);
        checkOutput("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'hF, 1'b1);
        checkOutput("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'hF, 1'b1);
        checkOutput("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'hF, 1'b1);
        checkOutput("rr_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Weight 3 on requester 0: three back-to-back grants before rotating
        weight = 16'h1113;
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_a", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_b0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_b1", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_b2", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_c", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_d0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_d1", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b1);
        checkOutput("w_d2", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Locking: grant held without done, even after the request drops
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("lock_issue", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0100, 1'b0);
            checkOutput("lock_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("lock_req_drop", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("lock_release", 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_done_ignored", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Pointer now 3: picking from 3 wraps to requester 1
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("idle_wrap_pick", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Reset mid-ownership clears grant and pointer
        applyStimulus(1'b1, 4'b1010, 1'b0);
        checkOutput("reset_mid_own", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1010, 1'b0);
        checkOutput("post_reset_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Zero weight on requester 3 behaves as weight 1
        weight = 16'h0111;
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("w0_issue", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("w0_rotates", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Owner 0 never completes: watchdog revoke (or indefinite hold without it)
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("reset_again", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("to_issue", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 4'b0011, 1'b0);
            checkOutput("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`ifdef WRR_TIMEOUT_EN
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("to_revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("to_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("no_to_hold8", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0011, 1'b0);
        checkOutput("no_to_hold9", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
